fft_index_counter: RTL and testbench
====================================

FFT_INDEX_COUNTER -- requirements
Module: fft_index_counter

Interface
REQ-001 Parameter WIDTH, default 5: counter width in bits; legal range 1..16.
REQ-002 Parameter MODULO, default 32: count range is 0..MODULO-1; legal range 2..2^WIDTH.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 clr  in  1  reset; synchronous, active-low.
REQ-005 start  in  1  begins a counting pass from the start value.
REQ-006 load  in  1  synchronously loads load_val into count.
REQ-007 load_val  in  WIDTH  value for load.
REQ-008 en  in  1  step enable; count advances only when high in RUN.
REQ-009 dir  in  1  1 = count up, 0 = count down; sampled every cycle.
REQ-010 oneshot  in  1  1 = stop after one pass, 0 = free-run with wrap; sampled at the terminal step.
REQ-011 count  out  WIDTH  current index, registered.
REQ-012 count_rev  out  WIDTH  count bit-reversed over WIDTH bits (bit i = count[WIDTH-1-i]), combinational from count.
REQ-013 tc  out  1  terminal-count indicator, combinational.
REQ-014 wrap  out  1  registered one-cycle pulse per completed pass.
REQ-015 busy  out  1  high in RUN state.
REQ-016 done  out  1  high in DONE state.

Function
REQ-017 FSM states: IDLE, RUN, DONE, each encoded as a distinct register value.
REQ-018 Start value: 0 when dir=1, MODULO-1 when dir=0; terminal value: MODULO-1 when dir=1, 0 when dir=0.
REQ-019 Per-cycle priority: clr, then start, then load, then en step, then hold.
REQ-020 start=1 in any state: count <= start value for the current dir, state <= RUN, wrap <= 0.
REQ-021 load=1 with start=0: count <= load_val, or MODULO-1 if load_val >= MODULO; state is unchanged and wrap <= 0.
REQ-022 In RUN with en=1 and count != terminal value: count <= count+1 (dir=1) or count-1 (dir=0), and wrap <= 0.
REQ-023 In RUN with en=1 and count == terminal value and oneshot=0: count <= start value (MODULO-1 -> 0 up, 0 -> MODULO-1 down), wrap <= 1, state stays RUN.
REQ-024 In RUN with en=1 and count == terminal value and oneshot=1: count holds at the terminal value, wrap <= 1, state <= DONE.
REQ-025 en=0, or state IDLE/DONE without start/load: count holds and wrap <= 0.
REQ-026 wrap is high for exactly one cycle per terminal step; back-to-back passes with en held high give one pulse every MODULO cycles.
REQ-027 tc = 1 when state is RUN and count equals the terminal value for the current dir, otherwise 0.
REQ-028 Changing dir mid-pass takes effect on the next step from the current count; a count that is then at the new terminal value follows REQ-023/024.
REQ-029 Arithmetic is modulo MODULO; count never leaves 0..MODULO-1, including for non-power-of-two MODULO.
REQ-030 DONE is left only via start (to RUN) or clr (to IDLE); load in DONE updates count only.

Reset
REQ-031 clr=0 at a rising edge: state <= IDLE, count <= 0, wrap <= 0, so busy=0, done=0, tc=0, count_rev=0.
REQ-032 clr overrides start, load and en in the same cycle, including mid-pass and in DONE.
REQ-033 After clr is released, the block stays in IDLE with count=0 until start.

Verification
REQ-034 Defaults; clr low 2 cycles; start, dir=1, oneshot=0, en=1 for 70 cycles -> count 0..31 repeating; wrap pulses on the cycle after each count=31; count_rev=16 when count=1.
REQ-035 MODULO=12, dir=0, oneshot=1; start, then en=1 -> count 11,10..0, tc=1 at 0, wrap one pulse, done=1, count held at 0 for 5 further en cycles.
REQ-036 Defaults, RUN at count=7: en toggled 1,0,0,1 -> count 8,8,8,9; wrap stays 0.
REQ-037 Defaults, load=1 with load_val=30, then en=1 -> 30, 31, 0, and wrap pulses; MODULO=12 with load_val=15 -> count=11.
REQ-038 start and load in the same cycle -> count = start value; clr low during RUN at count=20 with start=1 -> count=0, state IDLE, wrap=0.
REQ-039 dir switched from 1 to 0 at count=5 in RUN -> count 4,3; done via oneshot, then start -> busy=1, done=0, count reloaded.

Source files
------------

// File: rtl/fft_index_counter_if.sv
// fft_index_counter_if
//   Bundles the control inputs and index outputs of fft_index_counter.
//   master : the controller side (drives start/load/load_val/en/dir/oneshot,
//            observes count/count_rev/tc/wrap/busy/done)
//   slave  : the counter itself
//   WIDTH must match the WIDTH of the attached counter.
interface fft_index_counter_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             dir;
  logic             oneshot;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_rev;
  logic             tc;
  logic             wrap;
  logic             busy;
  logic             done;

  modport master (
    output start, load, load_val, en, dir, oneshot,
    input  count, count_rev, tc, wrap, busy, done
  );

  modport slave (
    input  start, load, load_val, en, dir, oneshot,
    output count, count_rev, tc, wrap, busy, done
  );
endinterface

// File: rtl/fft_index_counter.sv
// fft_index_counter
//   Modulo-MODULO up/down index counter for FFT address generation, with a
//   bit-reversed view of the index, one-shot or free-running passes and a
//   one-cycle wrap pulse at the end of every pass.
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-low reset (IDLE, count 0, wrap 0)
//   bus.slave  start/load/load_val/en/dir/oneshot in;
//              count (registered), count_rev (bit-reversed count),
//              tc (terminal count while running), wrap (registered pulse),
//              busy (RUN), done (DONE) out
// Parameters:
//   WIDTH   counter width, 1..16
//   MODULO  count range 0..MODULO-1, 2..2**WIDTH
module fft_index_counter #(
  parameter int WIDTH  = 5,
  parameter int MODULO = 32
) (
  input  logic                clk,
  input  logic                clr,
  fft_index_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;

  logic [WIDTH-1:0] start_v;
  logic [WIDTH-1:0] term_v;
  logic             at_term;
  logic [WIDTH-1:0] count_rev_c;

  // Start/terminal values follow the direction sampled this cycle, so a
  // mid-pass dir change retargets the terminal from the current count.
  always_comb begin
    start_v = bus.dir ? ZERO_V : MAX_V;
    term_v  = bus.dir ? MAX_V  : ZERO_V;
    at_term = (count_q == term_v);
  end

  // Next-state logic: start > load > en step > hold (clr handled in the flop).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.start) begin
      count_d = start_v;
      state_d = S_RUN;
    end else if (bus.load) begin
      // Out-of-range load values clamp to the top of the range.
      count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end else if ((state_q == S_RUN) && bus.en) begin
      if (!at_term) begin
        // Not at terminal, so +1/-1 cannot leave 0..MODULO-1.
        count_d = bus.dir ? (count_q + ONE_V) : (count_q - ONE_V);
      end else begin
        wrap_d = 1'b1;
        if (bus.oneshot) begin
          state_d = S_DONE;
        end else begin
          count_d = start_v;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    count_rev_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_rev_c[i] = count_q[WIDTH-1-i];
    end
  end

  assign bus.count     = count_q;
  assign bus.count_rev = count_rev_c;
  assign bus.tc        = (state_q == S_RUN) && at_term;
  assign bus.wrap      = wrap_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_fft_index_counter.sv
// Testbench for fft_index_counter: DUT A uses the defaults (WIDTH 5,
// MODULO 32), DUT B uses WIDTH 4, MODULO 12. The stimulus process pushes
// the expected post-edge outputs into a per-DUT queue; the monitor pops one
// entry after each rising edge and compares.
module tb_fft_index_counter;

  logic clk = 1'b0;
  logic clr_a, clr_b;
  always #5 clk = ~clk;

  fft_index_counter_if #(.WIDTH(5)) ia ();
  fft_index_counter_if #(.WIDTH(4)) ib ();

  fft_index_counter #(.WIDTH(5), .MODULO(32)) dut_a (.clk(clk), .clr(clr_a), .bus(ia));
  fft_index_counter #(.WIDTH(4), .MODULO(12)) dut_b (.clk(clk), .clr(clr_b), .bus(ib));

  typedef struct {
    string nm;
    int    cnt;
    bit    tc;
    bit    wr;
    bit    bz;
    bit    dn;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ma, mb;
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic int revf(input int v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++) begin
      if (v[i]) r = r | (1 << (w - 1 - i));
    end
    return r;
  endfunction

  // Monitor: one expectation per DUT per clock when present.
  always @(posedge clk) begin
    #1;
    if (qa.size() != 0) begin
      ma = qa.pop_front();
      n_chk++;
      if (ia.count !== 5'(ma.cnt) || ia.count_rev !== 5'(revf(ma.cnt, 5)) ||
          ia.tc !== ma.tc || ia.wrap !== ma.wr || ia.busy !== ma.bz || ia.done !== ma.dn)
        $display("FAIL A.%s: got count=%0d rev=%0d tc=%b wrap=%b busy=%b done=%b, want count=%0d rev=%0d tc=%b wrap=%b busy=%b done=%b",
                 ma.nm, ia.count, ia.count_rev, ia.tc, ia.wrap, ia.busy, ia.done,
                 ma.cnt, revf(ma.cnt, 5), ma.tc, ma.wr, ma.bz, ma.dn);
      else
        n_pass++;
    end
    if (qb.size() != 0) begin
      mb = qb.pop_front();
      n_chk++;
      if (ib.count !== 4'(mb.cnt) || ib.count_rev !== 4'(revf(mb.cnt, 4)) ||
          ib.tc !== mb.tc || ib.wrap !== mb.wr || ib.busy !== mb.bz || ib.done !== mb.dn)
        $display("FAIL B.%s: got count=%0d rev=%0d tc=%b wrap=%b busy=%b done=%b, want count=%0d rev=%0d tc=%b wrap=%b busy=%b done=%b",
                 mb.nm, ib.count, ib.count_rev, ib.tc, ib.wrap, ib.busy, ib.done,
                 mb.cnt, revf(mb.cnt, 4), mb.tc, mb.wr, mb.bz, mb.dn);
      else
        n_pass++;
    end
  end

  task automatic pa(input string nm, input int c, input bit tc, input bit wr, input bit bz, input bit dn);
    exp_t e;
    e.nm = nm; e.cnt = c; e.tc = tc; e.wr = wr; e.bz = bz; e.dn = dn;
    qa.push_back(e);
  endtask

  task automatic pb(input string nm, input int c, input bit tc, input bit wr, input bit bz, input bit dn);
    exp_t e;
    e.nm = nm; e.cnt = c; e.tc = tc; e.wr = wr; e.bz = bz; e.dn = dn;
    qb.push_back(e);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    clr_a = 1'b0; clr_b = 1'b0;
    ia.start = 0; ia.load = 0; ia.load_val = '0; ia.en = 0; ia.dir = 1; ia.oneshot = 0;
    ib.start = 0; ib.load = 0; ib.load_val = '0; ib.en = 0; ib.dir = 1; ib.oneshot = 0;

    // Reset: clr low two cycles
    for (int i = 0; i < 2; i++) begin
      nx();
      pa("reset", 0, 0, 0, 0, 0);
      pb("reset", 0, 0, 0, 0, 0);
    end
    // Released: stay IDLE even with en high
    nx(); clr_a = 1; clr_b = 1; ia.en = 1;
    pa("idle_hold", 0, 0, 0, 0, 0);
    nx();
    pa("idle_hold2", 0, 0, 0, 0, 0);

    // Free-run up, 70 steps
    nx(); ia.start = 1; ia.dir = 1; ia.oneshot = 0; ia.en = 1;
    pa("start_up", 0, 0, 0, 1, 0);
    nx(); ia.start = 0;
    for (int i = 1; i <= 71; i++) begin
      if (i > 1) nx();
      pa("freerun", i % 32, (i % 32) == 31, (i % 32) == 0, 1, 0);
    end
    // count is 7 here; en pattern 1,0,0,1
    nx(); ia.en = 1; pa("en_1", 8, 0, 0, 1, 0);
    nx(); ia.en = 0; pa("en_0a", 8, 0, 0, 1, 0);
    nx(); ia.en = 0; pa("en_0b", 8, 0, 0, 1, 0);
    nx(); ia.en = 1; pa("en_1b", 9, 0, 0, 1, 0);

    // Load 30 then step through the wrap
    nx(); ia.en = 0; ia.load = 1; ia.load_val = 5'd30; pa("load30", 30, 0, 0, 1, 0);
    nx(); ia.load = 0; ia.en = 1; pa("load_31", 31, 1, 0, 1, 0);
    nx(); pa("load_wrap", 0, 0, 1, 1, 0);
    nx(); pa("load_1", 1, 0, 0, 1, 0);

    // start and load together: start wins
    nx(); ia.start = 1; ia.load = 1; ia.load_val = 5'd20; pa("start_load", 0, 0, 0, 1, 0);
    nx(); ia.start = 0; ia.load = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) nx();
      pa("to20", k, 0, 0, 1, 0);
    end
    // clr at count 20 overrides start/load/en
    nx(); clr_a = 0; ia.start = 1; ia.load = 1; pa("clr_run", 0, 0, 0, 0, 0);
    nx(); clr_a = 1; ia.start = 0; ia.load = 0; pa("post_clr", 0, 0, 0, 0, 0);

    // dir change mid-pass, one-shot down to DONE
    nx(); ia.start = 1; ia.dir = 1; ia.oneshot = 1; ia.en = 0; pa("os_start", 0, 0, 0, 1, 0);
    nx(); ia.start = 0; ia.en = 1;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) nx();
      pa("os_up", k, 0, 0, 1, 0);
    end
    nx(); ia.dir = 0; pa("dn_4", 4, 0, 0, 1, 0);
    nx(); pa("dn_3", 3, 0, 0, 1, 0);
    nx(); pa("dn_2", 2, 0, 0, 1, 0);
    nx(); pa("dn_1", 1, 0, 0, 1, 0);
    nx(); pa("dn_0_tc", 0, 1, 0, 1, 0);
    nx(); pa("done_wrap", 0, 0, 1, 0, 1);
    nx(); pa("done_hold", 0, 0, 0, 0, 1);
    nx(); ia.load = 1; ia.load_val = 5'd9; pa("done_load", 9, 0, 0, 0, 1);
    nx(); ia.load = 0; ia.start = 1; ia.dir = 0; pa("restart", 31, 0, 0, 1, 0);
    nx(); ia.start = 0; ia.en = 0; pa("restart_hold", 31, 0, 0, 1, 0);

    // DUT B, MODULO 12: one-shot down pass
    nx(); ib.start = 1; ib.dir = 0; ib.oneshot = 1; ib.en = 1; pb("b_start", 11, 0, 0, 1, 0);
    nx(); ib.start = 0;
    for (int k = 10; k >= 0; k--) begin
      if (k < 10) nx();
      pb("b_down", k, k == 0, 0, 1, 0);
    end
    nx(); pb("b_done", 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      nx(); pb("b_done_hold", 0, 0, 0, 0, 1);
    end
    nx(); ib.en = 0; ib.load = 1; ib.load_val = 4'd15; pb("b_load_clamp", 11, 0, 0, 0, 1);

    // DUT B free-run up and down wraps
    nx(); ib.load = 0; ib.start = 1; ib.dir = 1; ib.oneshot = 0; ib.en = 1; pb("b_up_start", 0, 0, 0, 1, 0);
    nx(); ib.start = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) nx();
      pb("b_up", k, k == 11, 0, 1, 0);
    end
    nx(); pb("b_up_wrap", 0, 0, 1, 1, 0);
    nx(); pb("b_up_1", 1, 0, 0, 1, 0);
    nx(); ib.dir = 0; pb("b_dn_0", 0, 1, 0, 1, 0);
    nx(); pb("b_dn_wrap", 11, 0, 1, 1, 0);
    nx(); pb("b_dn_10", 10, 0, 0, 1, 0);
    nx(); clr_b = 0; ib.start = 1; pb("b_clr", 0, 0, 0, 0, 0);
    nx(); clr_b = 1; ib.start = 0; pb("b_post_clr", 0, 0, 0, 0, 0);

    nx(); nx();
    if (qa.size() != 0 || qb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", qa.size(), qb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
